// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, owner IDs,
// the latched access record and the range-check helper.
package dmem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int DMEM_DEPTH = 32;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } acc_t;

    function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating DMA wait counter; override goes high once DMA has waited MAX_WAIT cycles.
module dmem_starve_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic override
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!dma_req || dma_gnt)
            cnt_d = 8'd0;
        else if (cnt_q < 8'(MAX_WAIT))
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end

    assign override = (cnt_q >= 8'(MAX_WAIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of the single-port data memory.
// One access in flight: IDLE (grant) -> CMD (strobe) -> RESP (completion pulse).
import dmem_port_arbiter_pkg::*;

module dmem_port_arbiter #(
    parameter int DEPTH    = DMEM_DEPTH,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [1:0]  state_q, state_d;
    acc_t        acc_q, acc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        override;
    logic [31:0] resp_data;
    logic        resp_vld;

    dmem_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .dma_req  (dma_req),
        .dma_gnt  (dma_gnt),
        .override (override)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // CPU has priority until the DMA has starved long enough
                if (!rst) begin
                    if (dma_req && (override || !cpu_req)) dma_gnt = 1'b1;
                    else if (cpu_req)                      cpu_gnt = 1'b1;
                end
                if (dma_gnt) begin
                    acc_d   = '{owner: OWN_DMA, we: dma_we, addr: dma_addr, wdata: dma_wdata,
                                err: addr_oob(dma_addr, 32'(DEPTH))};
                    state_d = ST_CMD;
                end else if (cpu_gnt) begin
                    acc_d   = '{owner: OWN_CPU, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata,
                                err: addr_oob(cpu_addr, 32'(DEPTH))};
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                rdata_d = mem_rdata;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (state_q == ST_CMD) begin
            mem_addr  = acc_q.addr;
            mem_wdata = acc_q.wdata;
            mem_read  = !acc_q.we && !acc_q.err;
            mem_write = acc_q.we && !acc_q.err && !rst;
        end
    end

    assign resp_vld  = (state_q == ST_RESP) && !rst;
    assign resp_data = (!acc_q.we && !acc_q.err) ? rdata_q : 32'd0;

    always_comb begin
        cpu_rvalid = 1'b0;
        cpu_rdata  = 32'd0;
        cpu_err    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = 32'd0;
        dma_err    = 1'b0;
        if (resp_vld) begin
            if (acc_q.owner == OWN_DMA) begin
                dma_rvalid = 1'b1;
                dma_rdata  = resp_data;
                dma_err    = acc_q.err;
            end else begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = resp_data;
                cpu_err    = acc_q.err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 32-word memory model behind it.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_init;
    logic [31:0] mem [0:31];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DEPTH(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // D_MEM model: combinational read, write on posedge
    assign mem_rdata = (mem_read && mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
        end else if (mem_write && mem_addr < 32) begin
            mem[mem_addr[4:0]] <= mem_wdata;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int cpu_cnt;
        int dma_cyc;
        int dvld_cyc;
        logic [31:0] dvld_data;

        rst = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
        step; step;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        step;

        // release reset; CPU store addr 3
        rst = 1'b0; mem_init = 1'b0; dma_req = 1'b0;
        cpu_we = 1'b1; cpu_addr = 32'd3; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("st_cpu_gnt", cpu_gnt, 1);
        chk("st_dma_gnt", dma_gnt, 0);
        step;
        cpu_req = 1'b0;
        #1;
        chk("st_cmd_write", mem_write, 1);
        chk("st_cmd_read", mem_read, 0);
        chk("st_cmd_addr", mem_addr, 32'd3);
        chk("st_cmd_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_cmd_rvalid", cpu_rvalid, 0);
        step;
        #1;
        chk("st_resp_rvalid", cpu_rvalid, 1);
        chk("st_resp_rdata", cpu_rdata, 0);
        chk("st_resp_err", cpu_err, 0);
        chk("st_resp_strobe", mem_write, 0);
        step;

        // CPU load addr 3
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
        #1;
        chk("ld_cpu_gnt", cpu_gnt, 1);
        step;
        cpu_req = 1'b0;
        #1;
        chk("ld_cmd_read", mem_read, 1);
        chk("ld_cmd_addr", mem_addr, 32'd3);
        chk("ld_cmd_wdata_zero", mem_write, 0);
        step;
        #1;
        chk("ld_resp_rvalid", cpu_rvalid, 1);
        chk("ld_resp_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld_resp_dma_rvalid", dma_rvalid, 0);
        step;
        #1;
        chk("idle_addr_zero", mem_addr, 0);

        // starvation: both request every cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd2;
        cpu_cnt = 0; dma_cyc = -1; dvld_cyc = -1; dvld_data = 32'h0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (cpu_gnt) cpu_cnt++;
            if (dma_gnt && dma_cyc < 0) dma_cyc = c;
            if (dma_rvalid) begin dvld_cyc = c; dvld_data = dma_rdata; end
            step;
            if (dma_cyc >= 0) dma_req = 1'b0;
        end
        chk("starve_cpu_grants", cpu_cnt, 3);
        chk("starve_dma_cycle", dma_cyc, 9);
        chk("starve_dma_rvalid_cycle", dvld_cyc, 11);
        chk("starve_dma_rdata", dvld_data, 32'h1002);
        // counter cleared by the DMA grant: CPU wins again
        dma_req = 1'b1;
        #1;
        chk("cnt_clr_cpu_gnt", cpu_gnt, 1);
        chk("cnt_clr_dma_gnt", dma_gnt, 0);
        step;
        cpu_req = 1'b0; dma_req = 1'b0;
        step;
        #1;
        chk("cnt_clr_cpu_rdata", cpu_rdata, 32'h1001);
        step;

        // DMA load out of range
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd32;
        #1;
        chk("oob_dma_gnt", dma_gnt, 1);
        step;
        dma_req = 1'b0;
        #1;
        chk("oob_strobes", {mem_read, mem_write}, 0);
        step;
        #1;
        chk("oob_dma_rvalid", dma_rvalid, 1);
        chk("oob_dma_err", dma_err, 1);
        chk("oob_dma_rdata", dma_rdata, 0);
        step;

        // reset in CMD of a CPU store to addr 5
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'h55AA55AA;
        #1;
        chk("rstcmd_gnt", cpu_gnt, 1);
        step;
        cpu_req = 1'b0; rst = 1'b1;
        #1;
        chk("rstcmd_mem_write", mem_write, 0);
        step;
        rst = 1'b0;
        #1;
        chk("rstcmd_rvalid_a", cpu_rvalid, 0);
        step;
        #1;
        chk("rstcmd_rvalid_b", cpu_rvalid, 0);
        chk("rstcmd_mem5", mem[5], 32'h1005);

        // load addr 5 back, then a short request pulse during RESP
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5;
        #1;
        chk("rd5_gnt", cpu_gnt, 1);
        step;
        cpu_req = 1'b0;
        step;
        cpu_req = 1'b1;
        #1;
        chk("rd5_rdata", cpu_rdata, 32'h1005);
        chk("resp_req_no_gnt", cpu_gnt, 0);
        step;
        cpu_req = 1'b0;
        #1;
        chk("drop_no_gnt", cpu_gnt, 0);
        step;
        #1;
        chk("drop_no_access", {mem_read, mem_write}, 0);
        chk("drop_no_rvalid", cpu_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
